python_spi_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single PYTHON300 SPI register master.
- Port s0 serves the I2C command bridge; port s1 serves the sensor power-up/init sequencer.
- Grants one complete transaction at a time, round-robin between ports. A read stays locked until its read data returns, then the data is routed to the owning requester.
- Optional read-timeout watchdog keeps the bus from hanging.

---
 rtl/python_spi_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_python_spi_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/python_spi_arbiter.sv
//============================================================================
// Module      : python_spi_arbiter
// Description : Two-port round-robin arbiter and sequencer in front of the
//               single PYTHON300 SPI register master. Port s0 serves the I2C
//               command bridge, port s1 the power-up/init sequencer. One
//               complete transaction is outstanding at a time; reads stay
//               locked until their data returns to the owning port.
//               Optional read-timeout watchdog: define
//               PYTHON_SPI_ARB_TIMEOUT_EN to enable it.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module python_spi_arbiter #(
   parameter int ADDR_BITS      = 9,
   parameter int DATA_BITS      = 16,
   parameter int TIMEOUT_CYCLES = 4095
) (
   input  logic                 clk,
   input  logic                 reset_n,
   // port 0 : I2C command bridge
   input  logic [ADDR_BITS-1:0] s0_addr,
   input  logic                 s0_we,
   input  logic [DATA_BITS-1:0] s0_wdata,
   input  logic                 s0_valid,
   output logic                 s0_ready,
   output logic [DATA_BITS-1:0] s0_rdata,
   output logic                 s0_rvalid,
   // port 1 : power-up / init sequencer
   input  logic [ADDR_BITS-1:0] s1_addr,
   input  logic                 s1_we,
   input  logic [DATA_BITS-1:0] s1_wdata,
   input  logic                 s1_valid,
   output logic                 s1_ready,
   output logic [DATA_BITS-1:0] s1_rdata,
   output logic                 s1_rvalid,
   // SPI register master
   output logic [ADDR_BITS-1:0] m_addr,
   output logic                 m_we,
   output logic [DATA_BITS-1:0] m_wdata,
   output logic                 m_valid,
   input  logic                 m_ready,
   input  logic [DATA_BITS-1:0] m_rdata,
   input  logic                 m_rvalid,
   // status
   output logic                 busy,
   output logic                 grant,
   output logic                 timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT_RD = 2'd2
   } state_t;

   // Reject a watchdog period that could never expire.
   if (TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("python_spi_arbiter: TIMEOUT_CYCLES must be >= 1");
   end

   state_t               r_state;
   logic                 r_last_grant;
   logic                 r_grant;
   logic [ADDR_BITS-1:0] r_m_addr;
   logic                 r_m_we;
   logic [DATA_BITS-1:0] r_m_wdata;
   logic                 r_m_valid;
   logic [DATA_BITS-1:0] r_s0_rdata;
   logic                 r_s0_rvalid;
   logic [DATA_BITS-1:0] r_s1_rdata;
   logic                 r_s1_rvalid;

   logic                 w_any_valid;
   logic                 w_sel;
   logic                 w_accept;

`ifdef PYTHON_SPI_ARB_TIMEOUT_EN
   localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [c_TO_W-1:0]    r_to_cnt;
   logic                 r_timeout_err;
   logic                 w_expired;

   // Expiry fires on the TIMEOUT_CYCLES-th cycle spent in WAIT_RD.
   assign w_expired   = (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err = r_timeout_err;
`else
   assign timeout_err = 1'b0;
`endif

   // Round-robin pick: a lone requester wins, a tie goes away from last_grant.
   always_comb begin
      w_any_valid = s0_valid | s1_valid;
      if (s0_valid && s1_valid) begin
         w_sel = ~r_last_grant;
      end else begin
         w_sel = s1_valid;
      end
      w_accept = (r_state == ST_IDLE) && w_any_valid;
   end

   assign s0_ready  = w_accept && (w_sel == 1'b0);
   assign s1_ready  = w_accept && (w_sel == 1'b1);

   assign m_addr    = r_m_addr;
   assign m_we      = r_m_we;
   assign m_wdata   = r_m_wdata;
   assign m_valid   = r_m_valid;
   assign s0_rdata  = r_s0_rdata;
   assign s0_rvalid = r_s0_rvalid;
   assign s1_rdata  = r_s1_rdata;
   assign s1_rvalid = r_s1_rvalid;
   assign busy      = (r_state != ST_IDLE);
   assign grant     = r_grant;

   // Transaction sequencer: accept, issue to the SPI master, await read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_last_grant  <= 1'b1;
         r_grant       <= 1'b0;
         r_m_addr      <= '0;
         r_m_we        <= 1'b0;
         r_m_wdata     <= '0;
         r_m_valid     <= 1'b0;
         r_s0_rdata    <= '0;
         r_s0_rvalid   <= 1'b0;
         r_s1_rdata    <= '0;
         r_s1_rvalid   <= 1'b0;
`ifdef PYTHON_SPI_ARB_TIMEOUT_EN
         r_to_cnt      <= '0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
         // read strobes are single-cycle pulses
         r_s0_rvalid <= 1'b0;
         r_s1_rvalid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_m_addr     <= w_sel ? s1_addr  : s0_addr;
                  r_m_we       <= w_sel ? s1_we    : s0_we;
                  r_m_wdata    <= w_sel ? s1_wdata : s0_wdata;
                  r_m_valid    <= 1'b1;
                  r_grant      <= w_sel;
                  r_last_grant <= w_sel;
                  r_state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (m_ready) begin
                  r_m_valid <= 1'b0;
                  r_state   <= r_m_we ? ST_IDLE : ST_WAIT_RD;
`ifdef PYTHON_SPI_ARB_TIMEOUT_EN
                  r_to_cnt  <= '0;
`endif
               end
            end
            ST_WAIT_RD: begin
               // real data wins over a watchdog expiry in the same cycle
               if (m_rvalid) begin
                  if (r_grant) begin
                     r_s1_rdata  <= m_rdata;
                     r_s1_rvalid <= 1'b1;
                  end else begin
                     r_s0_rdata  <= m_rdata;
                     r_s0_rvalid <= 1'b1;
                  end
                  r_state <= ST_IDLE;
               end
`ifdef PYTHON_SPI_ARB_TIMEOUT_EN
               else if (w_expired) begin
                  if (r_grant) begin
                     r_s1_rdata  <= {DATA_BITS{1'b1}};
                     r_s1_rvalid <= 1'b1;
                  end else begin
                     r_s0_rdata  <= {DATA_BITS{1'b1}};
                     r_s0_rvalid <= 1'b1;
                  end
                  r_timeout_err <= 1'b1;
                  r_state       <= ST_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
`endif
            end
            default: begin
               r_state   <= ST_IDLE;
               r_m_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_python_spi_arbiter.sv
//============================================================================
// Module      : tb_python_spi_arbiter
// Description : Directed self-checking bench for python_spi_arbiter.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_python_spi_arbiter;

   localparam int AB = 9;
   localparam int DB = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AB-1:0] s0_addr, s1_addr, m_addr;
   logic          s0_we, s1_we, m_we;
   logic [DB-1:0] s0_wdata, s1_wdata, m_wdata;
   logic          s0_valid, s1_valid, s0_ready, s1_ready;
   logic [DB-1:0] s0_rdata, s1_rdata, m_rdata;
   logic          s0_rvalid, s1_rvalid;
   logic          m_valid, m_ready, m_rvalid;
   logic          busy, grant, timeout_err;

   int checks = 0;
   int errors = 0;

   python_spi_arbiter #(
      .ADDR_BITS      (AB),
      .DATA_BITS      (DB),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .s0_addr     (s0_addr),
      .s0_we       (s0_we),
      .s0_wdata    (s0_wdata),
      .s0_valid    (s0_valid),
      .s0_ready    (s0_ready),
      .s0_rdata    (s0_rdata),
      .s0_rvalid   (s0_rvalid),
      .s1_addr     (s1_addr),
      .s1_we       (s1_we),
      .s1_wdata    (s1_wdata),
      .s1_valid    (s1_valid),
      .s1_ready    (s1_ready),
      .s1_rdata    (s1_rdata),
      .s1_rvalid   (s1_rvalid),
      .m_addr      (m_addr),
      .m_we        (m_we),
      .m_wdata     (m_wdata),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_rdata     (m_rdata),
      .m_rvalid    (m_rvalid),
      .busy        (busy),
      .grant       (grant),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      s0_addr = '0; s0_we = 1'b0; s0_wdata = '0; s0_valid = 1'b0;
      s1_addr = '0; s1_we = 1'b0; s1_wdata = '0; s1_valid = 1'b0;
      m_ready = 1'b1; m_rdata = '0; m_rvalid = 1'b0;
   endtask

   task automatic test_reset;
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0", grant); end
      checks++; if (m_addr !== 9'h000 || m_we !== 1'b0 || m_wdata !== 16'h0000) begin errors++; $display("FAIL reset_m_bus: got %h/%b/%h expected 000/0/0000", m_addr, m_we, m_wdata); end
      checks++; if (s0_rdata !== 16'h0000 || s1_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0000/0000", s0_rdata, s1_rdata); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_write;
      s0_addr = 9'h010; s0_we = 1'b1; s0_wdata = 16'h1234; s0_valid = 1'b1;
      #1;
      checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin errors++; $display("FAIL wr_ready: got s0=%b s1=%b expected 1/0", s0_ready, s1_ready); end
      tick();
      s0_valid = 1'b0;
      checks++; if (m_valid !== 1'b1 || m_addr !== 9'h010 || m_we !== 1'b1 || m_wdata !== 16'h1234) begin errors++; $display("FAIL wr_issue: got v=%b a=%h we=%b d=%h expected 1/010/1/1234", m_valid, m_addr, m_we, m_wdata); end
      checks++; if (busy !== 1'b1 || grant !== 1'b0) begin errors++; $display("FAIL wr_busy_grant: got %b/%b expected 1/0", busy, grant); end
      tick();
      checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_done: got m_valid=%b busy=%b expected 0/0", m_valid, busy); end
      checks++; if (s0_rvalid !== 1'b0 || s1_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b/%b expected 0/0", s0_rvalid, s1_rvalid); end
   endtask

   task automatic test_read_s1;
      s1_addr = 9'h0FF; s1_we = 1'b0; s1_valid = 1'b1;
      #1;
      checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b expected 1", s1_ready); end
      tick();
      s1_valid = 1'b0;
      checks++; if (m_valid !== 1'b1 || m_addr !== 9'h0FF || m_we !== 1'b0 || grant !== 1'b1) begin errors++; $display("FAIL rd_issue: got v=%b a=%h we=%b g=%b expected 1/0ff/0/1", m_valid, m_addr, m_we, grant); end
      tick();
      repeat (4) tick();
      checks++; if (busy !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL rd_wait: got busy=%b m_valid=%b expected 1/0", busy, m_valid); end
      m_rvalid = 1'b1; m_rdata = 16'hBEEF;
      tick();
      m_rvalid = 1'b0; m_rdata = 16'h0000;
      checks++; if (s1_rvalid !== 1'b1 || s1_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_return: got v=%b d=%h expected 1/beef", s1_rvalid, s1_rdata); end
      checks++; if (s0_rvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_other_port: got s0_rvalid=%b busy=%b expected 0/0", s0_rvalid, busy); end
      tick();
      checks++; if (s1_rvalid !== 1'b0 || s1_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_pulse_hold: got v=%b d=%h expected 0/beef", s1_rvalid, s1_rdata); end
   endtask

   task automatic test_stray_rvalid;
      m_rvalid = 1'b1; m_rdata = 16'h7777;
      tick();
      m_rvalid = 1'b0;
      checks++; if (s0_rvalid !== 1'b0 || s1_rvalid !== 1'b0 || s1_rdata !== 16'hBEEF || s0_rdata !== 16'h0000) begin errors++; $display("FAIL stray_rvalid: got %b/%b %h/%h expected 0/0 0000/beef", s0_rvalid, s1_rvalid, s0_rdata, s1_rdata); end
   endtask

   task automatic test_read_lock;
      s0_addr = 9'h020; s0_we = 1'b0; s0_valid = 1'b1;
      #1;
      checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL lock_s0_ready: got %b expected 1", s0_ready); end
      tick();
      s0_valid = 1'b0;
      s1_addr = 9'h030; s1_we = 1'b1; s1_wdata = 16'h5555; s1_valid = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL lock_s1_blocked: got %b expected 0 (cycle %0d)", s1_ready, i); end
         tick();
      end
      m_rvalid = 1'b1; m_rdata = 16'hCAFE;
      #1;
      checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL lock_s1_at_rvalid: got %b expected 0", s1_ready); end
      tick();
      m_rvalid = 1'b0;
      checks++; if (s0_rvalid !== 1'b1 || s0_rdata !== 16'hCAFE || s1_rvalid !== 1'b0) begin errors++; $display("FAIL lock_return: got %b %h s1v=%b expected 1 cafe 0", s0_rvalid, s0_rdata, s1_rvalid); end
      checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL lock_s1_released: got %b expected 1", s1_ready); end
      tick();
      s1_valid = 1'b0;
      checks++; if (m_valid !== 1'b1 || m_addr !== 9'h030 || m_wdata !== 16'h5555 || grant !== 1'b1) begin errors++; $display("FAIL lock_s1_issue: got v=%b a=%h d=%h g=%b expected 1/030/5555/1", m_valid, m_addr, m_wdata, grant); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_s1_done: got busy=%b expected 0", busy); end
   endtask

   task automatic test_withdraw;
      s0_addr = 9'h044; s0_we = 1'b1; s0_valid = 1'b0;
      s1_addr = 9'h045; s1_we = 1'b1; s1_valid = 1'b0;
      m_ready = 1'b0;
      s0_valid = 1'b1;
      tick();
      s0_valid = 1'b0;
      s1_valid = 1'b1;
      tick();
      s1_valid = 1'b0;
      m_ready = 1'b1;
      #1;
      checks++; if (m_valid !== 1'b1 || m_addr !== 9'h044) begin errors++; $display("FAIL withdraw_stall: got v=%b a=%h expected 1/044", m_valid, m_addr); end
      tick();
      tick();
      checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL withdraw_no_latch: got m_valid=%b busy=%b expected 0/0", m_valid, busy); end
   endtask

   task automatic test_round_robin;
      logic [AB-1:0] exp_addr;
      int            waited;
      logic          who;
      idle_inputs();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      s0_addr = 9'h100; s0_we = 1'b1; s0_wdata = 16'hA000; s0_valid = 1'b1;
      s1_addr = 9'h101; s1_we = 1'b1; s1_wdata = 16'hB001; s1_valid = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         waited = 0;
         while (!(s0_ready || s1_ready) && waited < 10) begin
            tick();
            waited++;
         end
         checks++; if (waited >= 10) begin errors++; $display("FAIL rr_ready_timeout: got no ready in %0d cycles expected ready (txn %0d)", waited, k); end
         who      = s1_ready;
         exp_addr = (k % 2 == 1) ? 9'h101 : 9'h100;
         checks++; if (who !== k[0]) begin errors++; $display("FAIL rr_order: got port %0d expected port %0d (txn %0d)", who, k % 2, k); end
         tick();
         checks++; if (m_addr !== exp_addr || grant !== k[0]) begin errors++; $display("FAIL rr_issue: got a=%h g=%b expected %h/%0d (txn %0d)", m_addr, grant, exp_addr, k % 2, k); end
         tick();
      end
      s0_valid = 1'b0;
      s1_valid = 1'b0;
      tick();
   endtask

`ifdef PYTHON_SPI_ARB_TIMEOUT_EN
   task automatic test_timeout;
      int n;
      s1_addr = 9'h050; s1_we = 1'b0; s1_valid = 1'b1;
      tick();
      s1_valid = 1'b0;
      n = 1;
      while (s1_rvalid !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      checks++; if (n < 9 || n > 11) begin errors++; $display("FAIL to_latency: got %0d cycles expected 9..11", n); end
      checks++; if (s1_rdata !== 16'hFFFF || timeout_err !== 1'b1 || s0_rvalid !== 1'b0) begin errors++; $display("FAIL to_result: got d=%h err=%b s0v=%b expected ffff/1/0", s1_rdata, timeout_err, s0_rvalid); end
      s1_addr = 9'h051; s1_we = 1'b1; s1_wdata = 16'h0F0F; s1_valid = 1'b1;
      #1;
      checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL to_next_ready: got %b expected 1", s1_ready); end
      tick();
      s1_valid = 1'b0;
      checks++; if (m_valid !== 1'b1 || m_addr !== 9'h051 || m_we !== 1'b1) begin errors++; $display("FAIL to_next_issue: got v=%b a=%h we=%b expected 1/051/1", m_valid, m_addr, m_we); end
      tick();
      checks++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got busy=%b err=%b expected 0/1", busy, timeout_err); end
   endtask
`endif

   task automatic test_reset_midread;
      s0_addr = 9'h060; s0_we = 1'b0; s0_valid = 1'b1;
      s1_valid = 1'b0;
      m_ready = 1'b1;
      tick();
      s0_valid = 1'b0;
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_in_wait: got busy=%b expected 1", busy); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || m_valid !== 1'b0 || grant !== 1'b0 || m_addr !== 9'h000) begin errors++; $display("FAIL mid_async_reset: got busy=%b v=%b g=%b a=%h expected 0/0/0/000", busy, m_valid, grant, m_addr); end
      checks++; if (s0_rdata !== 16'h0000 || s1_rdata !== 16'h0000 || timeout_err !== 1'b0) begin errors++; $display("FAIL mid_reset_data: got %h/%h err=%b expected 0000/0000/0", s0_rdata, s1_rdata, timeout_err); end
      tick();
      reset_n = 1'b1;
      tick();
      m_rvalid = 1'b1; m_rdata = 16'h1111;
      tick();
      m_rvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++; if (s0_rvalid !== 1'b0 || s1_rvalid !== 1'b0 || s0_rdata !== 16'h0000 || busy !== 1'b0) begin errors++; $display("FAIL mid_late_rvalid: got %b/%b d=%h busy=%b expected 0/0 0000 0", s0_rvalid, s1_rvalid, s0_rdata, busy); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_s1();
      test_stray_rvalid();
      test_read_lock();
      test_withdraw();
      test_round_robin();
`ifdef PYTHON_SPI_ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_midread();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
